// File: rtl/sisc_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sisc_mux_pkg                                                    |
// | Purpose  : Shared constants and types for the SISC operand mux pipeline.   |
// |            Provides the default datapath width, the largest supported      |
// |            input count and the skid-buffer occupancy state type.           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package sisc_mux_pkg;

  localparam int MUX_PIPE_DEFAULT_WIDTH = 32;
  localparam int MUX_PIPE_MAX_IN        = 16;

  // Occupancy of the two-entry buffer: nothing, main only, main and skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } mux_pipe_state_t;

endpackage : sisc_mux_pkg
`default_nettype wire

// File: rtl/mux_nway.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux_nway                                                        |
// | Purpose  : Purely combinational NUM_IN-way, WIDTH-bit word selector with   |
// |            an in-range indication for the select.                          |
// | Ports    : in_data  [NUM_IN*WIDTH] concatenated words, word k at k*WIDTH   |
// |            sel      [SEL_W]        index of the word to forward            |
// |            out_data [WIDTH]        selected word (word 0 if out of range)  |
// |            sel_ok   [1]            sel addresses an existing input         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mux_nway #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_ok
);

  // Decoded compare per input rather than a variable part-select, so an
  // unused select code (non power-of-two NUM_IN) falls back to word 0
  // instead of reading past the end of the bus.
  always_comb begin
    out_data = in_data[WIDTH-1:0];
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

endmodule : mux_nway
`default_nettype wire

// File: rtl/mux_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux_pipe                                                        |
// | Purpose  : Registered N-way operand multiplexer with valid/ready handshake |
// |            and a two-entry skid buffer. Sustains one transfer per cycle;   |
// |            in_ready is derived from registers only (no out_ready path).    |
// | Option   : MUX_PIPE_SEL_CHECK_EN - when defined, an out-of-range in_sel    |
// |            is consumed without storing and pulses out_err for one cycle.   |
// |            When undefined, out-of-range selects input 0, out_err is 0.     |
// | Ports    : clk        clock, rising edge                                   |
// |            rst_f      synchronous active-low reset                         |
// |            in_data    [NUM_IN*WIDTH] concatenated inputs                   |
// |            in_sel     [SEL_W] input index, sampled with in_data            |
// |            in_valid / in_ready   upstream handshake                        |
// |            out_data   [WIDTH] selected word                                |
// |            out_sel    [SEL_W] index that produced out_data                 |
// |            out_valid / out_ready downstream handshake                      |
// |            out_err    dropped out-of-range select pulse                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mux_pipe
  import sisc_mux_pkg::*;
#(
  parameter int WIDTH  = MUX_PIPE_DEFAULT_WIDTH,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_f,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_err
);

  logic [WIDTH-1:0] mux_data;
  logic             sel_ok;

  mux_nway #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux_nway (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (mux_data),
    .sel_ok   (sel_ok)
  );

  mux_pipe_state_t  state;
  mux_pipe_state_t  state_nxt;
  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;

  logic push;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Skid is valid only in FULL; gating with rst_f keeps ready low in reset.
  assign in_ready  = rst_f && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign pop       = out_valid && out_ready;

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic err_q;
  logic push_bad;

  // A bad select still completes the handshake but never reaches storage.
  assign push     = in_valid && in_ready && sel_ok;
  assign push_bad = in_valid && in_ready && !sel_ok;
  assign out_err  = err_q;

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      err_q <= 1'b0;
    end else begin
      err_q <= push_bad;
    end
  end
`else
  logic unused_sel_ok;

  assign unused_sel_ok = sel_ok;
  assign push          = in_valid && in_ready;
  assign out_err       = 1'b0;
`endif

  // Next-state and load strobes. FULL never sees a push (in_ready low) and
  // EMPTY never sees a pop (out_valid low).
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state     <= EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_data <= mux_data;
        main_sel  <= in_sel;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_sel  <= skid_sel;
      end
      if (load_skid) begin
        skid_data <= mux_data;
        skid_sel  <= in_sel;
      end
    end
  end

endmodule : mux_pipe
`default_nettype wire

// File: tb/tb_mux_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mux_pipe                                                     |
// | Purpose  : Self-checking bench for mux_pipe. A 4-input instance covers     |
// |            reset, streaming, back-pressure, push/pop and mid-run reset; a  |
// |            3-input instance covers out-of-range selects (behaviour follows |
// |            MUX_PIPE_SEL_CHECK_EN).                                         |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mux_pipe;

  logic         clk = 1'b0;
  logic         rst_f;
  // 4-input instance
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;
  logic         out_err;
  // 3-input instance
  logic [95:0]  d3_in_data;
  logic [1:0]   d3_in_sel;
  logic         d3_in_valid;
  logic         d3_in_ready;
  logic [31:0]  d3_out_data;
  logic [1:0]   d3_out_sel;
  logic         d3_out_valid;
  logic         d3_out_ready;
  logic         d3_out_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [4];

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .rst_f(rst_f), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_err(out_err)
  );

  mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_f(rst_f), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_sel(d3_out_sel), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
    .out_err(d3_out_err)
  );

  task automatic test_reset();
    @(negedge clk);
    rst_f = 1'b0; in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b0;
    d3_in_valid = 1'b1; d3_in_sel = 2'd1; d3_out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready cyc%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid cyc%0d got=%b exp=0", c, out_valid); end
      checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data cyc%0d got=%h exp=0", c, out_data); end
      checks++; if (out_sel !== 2'd0) begin failures++; $display("FAIL reset_out_sel cyc%0d got=%0d exp=0", c, out_sel); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err cyc%0d got=%b exp=0", c, out_err); end
      checks++; if (d3_out_valid !== 1'b0) begin failures++; $display("FAIL reset_d3_out_valid cyc%0d got=%b exp=0", c, d3_out_valid); end
    end
    rst_f = 1'b1; in_valid = 1'b0; d3_in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    checks++; if (d3_in_ready !== 1'b1) begin failures++; $display("FAIL release_d3_in_ready got=%b exp=1", d3_in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid i=%0d got=%b exp=1", i, out_valid); end
        checks++; if (out_data !== words[i-1]) begin failures++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, out_data, words[i-1]); end
        checks++; if (out_sel !== 2'(i-1)) begin failures++; $display("FAIL stream_sel i=%0d got=%0d exp=%0d", i, out_sel, i-1); end
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL stream_err i=%0d got=%b exp=0", i, out_err); end
      in_valid = (i < 4);
      in_sel   = 2'(i);
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    checks++; if (out_data !== 32'h11111111) begin failures++; $display("FAIL bp_data_one got=%h exp=11111111", out_data); end
    in_sel = 2'd2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
    checks++; if (out_data !== 32'h11111111) begin failures++; $display("FAIL bp_data_hold got=%h exp=11111111", out_data); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h11111111 || out_sel !== 2'd1) begin
      failures++; $display("FAIL bp_stable got=%b/%h/%0d exp=1/11111111/1", out_valid, out_data, out_sel); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_stall got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_data !== 32'h22222222 || out_sel !== 2'd2) begin failures++; $display("FAIL bp_second got=%h/%0d exp=22222222/2", out_data, out_sel); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [6];
    logic [1:0] q [$];
    logic [15:0] vpat;
    logic [15:0] rpat;
    logic pu;
    logic po;
    seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd2; seq[3] = 2'd1; seq[4] = 2'd3; seq[5] = 2'd2;
    out_ready = 1'b1;
    // Steady push+pop in ONE: ready never drops, order kept.
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++; if (out_valid !== 1'b1 || out_data !== words[seq[i-1]] || out_sel !== seq[i-1]) begin
          failures++; $display("FAIL b2b_out i=%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_data, out_sel, words[seq[i-1]], seq[i-1]); end
      end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
      in_valid = (i < 6);
      in_sel   = (i < 6) ? seq[i] : 2'd0;
    end
    // Irregular valid/ready mix against a depth-2 FIFO model.
    vpat = 16'b1011_1110_0111_1101;
    rpat = 16'b0110_0011_1100_1010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== (q.size() > 0)) begin failures++; $display("FAIL mix_valid i=%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin failures++; $display("FAIL mix_ready i=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (out_data !== words[q[0]] || out_sel !== q[0]) begin
          failures++; $display("FAIL mix_data i=%0d got=%h/%0d exp=%h/%0d", i, out_data, out_sel, words[q[0]], q[0]); end
      end
      in_valid  = (i < 16) ? vpat[i] : 1'b0;
      in_sel    = 2'((i * 3 + 1) % 4);
      out_ready = (i < 16) ? rpat[i] : 1'b1;
      pu = in_valid && (q.size() < 2);
      po = out_ready && (q.size() > 0);
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in_sel);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
    @(negedge clk);
    in_sel = 2'd2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mr_full got=%b exp=0", in_ready); end
    rst_f = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL mr_cleared got=%b/%h exp=0/0", out_valid, out_data); end
    rst_f = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mr_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h33333333 || out_sel !== 2'd3) begin
      failures++; $display("FAIL mr_after got=%b/%h/%0d exp=1/33333333/3", out_valid, out_data, out_sel); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mr_lost got=%b exp=0", out_valid); end
  endtask

  task automatic test_range_check();
    @(negedge clk);
    d3_out_ready = 1'b0; d3_in_valid = 1'b1; d3_in_sel = 2'd1;
    @(negedge clk);
    checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'hBBBBBBBB || d3_out_sel !== 2'd1) begin
      failures++; $display("FAIL rc_first got=%b/%h/%0d exp=1/bbbbbbbb/1", d3_out_valid, d3_out_data, d3_out_sel); end
    checks++; if (d3_out_err !== 1'b0) begin failures++; $display("FAIL rc_err_idle got=%b exp=0", d3_out_err); end
    d3_in_sel = 2'd3;
    @(negedge clk);
`ifdef MUX_PIPE_SEL_CHECK_EN
    checks++; if (d3_out_err !== 1'b1) begin failures++; $display("FAIL rc_err_pulse got=%b exp=1", d3_out_err); end
    checks++; if (d3_in_ready !== 1'b1) begin failures++; $display("FAIL rc_not_stored got=%b exp=1", d3_in_ready); end
`else
    checks++; if (d3_out_err !== 1'b0) begin failures++; $display("FAIL rc_err_tied got=%b exp=0", d3_out_err); end
    checks++; if (d3_in_ready !== 1'b0) begin failures++; $display("FAIL rc_stored got=%b exp=0", d3_in_ready); end
`endif
    checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'hBBBBBBBB) begin
      failures++; $display("FAIL rc_main_kept got=%b/%h exp=1/bbbbbbbb", d3_out_valid, d3_out_data); end
    d3_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (d3_out_err !== 1'b0) begin failures++; $display("FAIL rc_err_end got=%b exp=0", d3_out_err); end
    d3_out_ready = 1'b1;
    @(negedge clk);
`ifdef MUX_PIPE_SEL_CHECK_EN
    checks++; if (d3_out_valid !== 1'b0) begin failures++; $display("FAIL rc_empty got=%b exp=0", d3_out_valid); end
`else
    checks++; if (d3_out_valid !== 1'b1 || d3_out_data !== 32'hAAAAAAAA || d3_out_sel !== 2'd3) begin
      failures++; $display("FAIL rc_fallback got=%b/%h/%0d exp=1/aaaaaaaa/3", d3_out_valid, d3_out_data, d3_out_sel); end
`endif
    @(negedge clk);
    checks++; if (d3_out_valid !== 1'b0) begin failures++; $display("FAIL rc_drain got=%b exp=0", d3_out_valid); end
  endtask

  initial begin
    words[0] = 32'h00000000; words[1] = 32'h11111111;
    words[2] = 32'h22222222; words[3] = 32'h33333333;
    in_data    = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    d3_in_data = {32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    rst_f = 1'b0; in_sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
    d3_in_sel = 2'd0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_range_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_mux_pipe
`default_nettype wire

// File: doc/mux_pipe.md
# mux_pipe

Parametrised, registered N-way datapath multiplexer with a valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed 4:1 32-bit combinational operand mux in the SISC datapath, generalised in width and input count. It sits between the operand sources (register file, immediate, swap paths) and the ALU/memory stage. It sustains one transfer per cycle under back-pressure without a combinational ready path from output to input.

## Interface
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 4, number of selectable inputs (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived; do not override)
- clk  input  1  single clock; all state changes on the rising edge
- rst_f  input  1  reset, synchronous, active-low
- in_data  input  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  index of the input to forward; sampled with in_data
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts a transfer this cycle
- out_data  output  WIDTH  selected word
- out_sel  output  SEL_W  index that produced out_data
- out_valid  output  1  out_data/out_sel valid
- out_ready  input  1  downstream accepts out_data this cycle
- out_err  output  1  one-cycle pulse on a dropped out-of-range select (MUX_PIPE_SEL_CHECK_EN only; tied 0 otherwise)

## Operation
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- On an input transfer, the word in_data[in_sel*WIDTH +: WIDTH] and in_sel are captured. The mux is combinational; all storage is after it.
- Storage: main register (drives outputs) and skid register. Three states:
  - EMPTY: main and skid both invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid both valid.
- Transitions:
  - EMPTY: input transfer -> ONE (load main).
  - ONE: input transfer and no output transfer -> FULL (load skid).
  - ONE: input transfer and output transfer -> ONE (reload main).
  - ONE: output transfer only -> EMPTY.
  - FULL: output transfer -> ONE (skid moves to main).
- in_ready = !skid_valid && rst_f. It is a register-derived signal and never depends on out_ready.
- out_valid = main_valid. out_data and out_sel stay stable while out_valid && !out_ready.
- Order is strictly preserved: FIFO semantics, depth 2.
- Reset (rst_f low at an edge): state becomes EMPTY; out_valid=0, out_data=0, out_sel=0, out_err=0. in_ready is 0 while rst_f is low. Any in-flight data is discarded, whatever the prior state.

## Timing
- Latency: an input accepted at edge N is visible on the outputs after edge N, i.e. 1 cycle.
- Throughput: 1 transfer/cycle whenever out_ready is held high.
- After out_ready drops, at most 2 words are absorbed, then in_ready falls in the cycle after the second capture.
- in_ready rises in the cycle after the output transfer that empties skid.
- First cycle with rst_f high: in_ready=1, out_valid=0.

## Configuration
- MUX_PIPE_SEL_CHECK_EN defined:
  - An input transfer with in_sel >= NUM_IN is consumed: the handshake completes but nothing is stored and the state is unchanged.
  - out_err pulses high for exactly the cycle after that edge.
  - Only meaningful when NUM_IN is not a power of two.
- MUX_PIPE_SEL_CHECK_EN undefined:
  - in_sel >= NUM_IN selects input 0, and out_sel reports the raw in_sel.
  - out_err is constant 0.

## Structure
- Shared package sisc_mux_pkg:
  - MUX_PIPE_DEFAULT_WIDTH=32 and MUX_PIPE_MAX_IN=16 constants.
  - A state enum type mux_pipe_state_t {EMPTY, ONE, FULL}.
- One sub-module is natural: mux_nway, a purely combinational WIDTH×NUM_IN selector (with its range check). mux_pipe instantiates it ahead of the skid-buffer control.

## Test plan
- Reset: drive rst_f=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0 throughout; first cycle after release in_ready=1.
- Streaming: NUM_IN=4, out_ready=1, in_data={D3,D2,D1,D0}={0x33333333,0x22222222,0x11111111,0x00000000}, sel 0,1,2,3 on consecutive cycles -> out_data 0x0,0x11111111,0x22222222,0x33333333 on the following 4 cycles, out_sel 0..3, no bubbles.
- Back-pressure: out_ready=0, send sel=1 then sel=2 -> in_ready falls after the second capture. Raise out_ready -> outputs 0x11111111 then 0x22222222; in_ready back to 1 one cycle after the first output transfer.
- Simultaneous push/pop in ONE: out_ready=1, continuous input -> state stays ONE, in_ready stays 1, order preserved.
- Mid-operation reset: in FULL, drop rst_f for 1 cycle -> out_valid=0, both stored words lost; subsequent sel=3 arrives as 0x33333333 after 1 cycle.
- Range check (NUM_IN=3, macro defined): in_sel=3 accepted -> out_err=1 for one cycle, out_valid unchanged. Same stimulus with the macro undefined -> out_data=input 0, out_sel=3, out_err=0.
